// File: rtl/instr_issuer.sv
// instr_issuer: byte-serial program loader and in-order 32-bit instruction issuer.
// Bytes arrive MSB first, are packed into words and stored; on start the words
// are presented over a valid/ready handshake at up to one word per cycle.
// Optional feature macro: HALT_OPCODE_EN (words with opcode 6'b111111 end the
// program instead of being issued).
module instr_issuer #(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_en,
   input  logic [7:0]        load_byte,
   input  logic              start,
   output logic [31:0]       instruccion,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W:0]   prog_len,
   output logic              busy,
   output logic              done,
   output logic              overflow
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [ADDR_W:0]   FULL_LEN = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   LEN_ONE  = 1;
   localparam logic [ADDR_W-1:0] PC_ONE   = 1;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [ADDR_W:0]     len_q, len_d;
   logic [1:0]          bcnt_q, bcnt_d;
   logic [23:0]         pack_q, pack_d;
   logic [31:0]         instr_q, instr_d;
   logic                valid_q, valid_d;
   logic                ovf_q, ovf_d;
   logic                mem_we;
   logic [31:0]         mem_wdata;
   logic [31:0]         mem [DEPTH];

   // Halt detection: only meaningful when the halt feature is built in.
   function automatic logic is_halt(input logic [31:0] w);
`ifdef HALT_OPCODE_EN
      return (w[31:26] == 6'b111111);
`else
      return 1'b0 & w[0];
`endif
   endfunction

   assign mem_wdata = {pack_q, load_byte};

   // Next-state logic: loading in IDLE, issuing in RUN, restart from DONE.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      len_d   = len_q;
      bcnt_d  = bcnt_q;
      pack_d  = pack_q;
      instr_d = instr_q;
      valid_d = valid_q;
      ovf_d   = ovf_q;
      mem_we  = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               // start discards any partial word and beats a same-cycle byte
               bcnt_d = '0;
               if (len_q == '0) begin
                  state_d = DONE;
                  valid_d = 1'b0;
               end else begin
                  state_d = RUN;
                  pc_d    = '0;
                  instr_d = mem[0];
                  // a halt word at index 0 is never shown; RUN then drops to DONE
                  valid_d = !is_halt(mem[0]);
               end
            end else if (state_q == IDLE && load_en) begin
               if (len_q == FULL_LEN) begin
                  ovf_d = 1'b1;
               end else begin
                  pack_d = {pack_q[15:0], load_byte};
                  bcnt_d = bcnt_q + 2'd1;
                  if (bcnt_q == 2'd3) begin
                     mem_we = 1'b1;
                     len_d  = len_q + LEN_ONE;
                  end
               end
            end
         end
         RUN: begin
            if (!valid_q) begin
               state_d = DONE;
            end else if (instr_ready) begin
               if ({1'b0, pc_q} == len_q - LEN_ONE) begin
                  valid_d = 1'b0;
                  state_d = DONE;
               end else begin
                  pc_d    = pc_q + PC_ONE;
                  instr_d = mem[pc_q + PC_ONE];
                  if (is_halt(mem[pc_q + PC_ONE])) begin
                     valid_d = 1'b0;
                     state_d = DONE;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         pc_q    <= '0;
         len_q   <= '0;
         bcnt_q  <= '0;
         pack_q  <= '0;
         instr_q <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         len_q   <= len_d;
         bcnt_q  <= bcnt_d;
         pack_q  <= pack_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
      end
   end

   // Program store write; contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we) mem[len_q[ADDR_W-1:0]] <= mem_wdata;
   end

   assign instruccion = instr_q;
   assign instr_valid = valid_q;
   assign pc          = pc_q;
   assign prog_len    = len_q;
   assign busy        = (state_q == RUN);
   assign done        = (state_q == DONE);
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_instr_issuer.sv
// Directed testbench for instr_issuer; expected values are hand-computed.
module tb_instr_issuer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load_en = 1'b0;
   logic [7:0]  load_byte = '0;
   logic        start = 1'b0;
   logic [31:0] instruccion;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [5:0]  pc;
   logic [6:0]  prog_len;
   logic        busy, done, overflow;

   int checks = 0;
   int errors = 0;

   instr_issuer #(.DEPTH(64), .ADDR_W(6)) dut (
      .clk(clk), .rst(rst), .load_en(load_en), .load_byte(load_byte),
      .start(start), .instruccion(instruccion), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .pc(pc), .prog_len(prog_len),
      .busy(busy), .done(done), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // advance one edge; outputs are sampled 1 time unit after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      load_en = 1'b1; load_byte = b;
      tick();
      load_en = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      send(w[31:24]); send(w[23:16]); send(w[15:8]); send(w[7:0]);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #2;
      rst = 1'b0;
      tick();
   endtask

   function automatic logic [31:0] wgen(input int i);
      logic [7:0] b;
      b = 8'(i);
      return {b, b + 8'd1, 8'hC3, ~b};
   endfunction

   initial begin
      // reset state
      #1;
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr", instruccion, 32'd0);
      chk("rst_pc", 32'(pc), 32'd0);
      chk("rst_len", 32'(prog_len), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      do_reset();

      // two-word program, ready held high
      send_word(32'h00430820);
      send_word(32'h00A43022);
      chk("t1_len", 32'(prog_len), 32'd2);
      instr_ready = 1'b1;
      pulse_start();
      chk("t1_v0", 32'(instr_valid), 32'd1);
      chk("t1_w0", instruccion, 32'h00430820);
      chk("t1_pc0", 32'(pc), 32'd0);
      chk("t1_busy", 32'(busy), 32'd1);
      tick();
      chk("t1_v1", 32'(instr_valid), 32'd1);
      chk("t1_w1", instruccion, 32'h00A43022);
      chk("t1_pc1", 32'(pc), 32'd1);
      tick();
      chk("t1_vend", 32'(instr_valid), 32'd0);
      chk("t1_done", 32'(done), 32'd1);
      chk("t1_pcend", 32'(pc), 32'd1);

      // restart from DONE with back-pressure
      instr_ready = 1'b0;
      pulse_start();
      for (int k = 0; k < 3; k++) begin
         chk("t2_hold_v", 32'(instr_valid), 32'd1);
         chk("t2_hold_w", instruccion, 32'h00430820);
         chk("t2_hold_pc", 32'(pc), 32'd0);
         if (k < 2) tick();
      end
      instr_ready = 1'b1;
      tick();
      chk("t2_w1", instruccion, 32'h00A43022);
      chk("t2_pc1", 32'(pc), 32'd1);
      tick();
      chk("t2_done", 32'(done), 32'd1);
      chk("t2_vend", 32'(instr_valid), 32'd0);

      // partial trailing word discarded
      do_reset();
      for (int k = 0; k < 4; k++) send(8'h11);
      send(8'hAA); send(8'hBB);
      chk("t3_len", 32'(prog_len), 32'd1);
      pulse_start();
      chk("t3_v", 32'(instr_valid), 32'd1);
      chk("t3_w", instruccion, 32'h11111111);
      tick();
      chk("t3_done", 32'(done), 32'd1);
      chk("t3_vend", 32'(instr_valid), 32'd0);

      // fill store, overflow, issue all 64
      do_reset();
      for (int i = 0; i < 64; i++) send_word(wgen(i));
      chk("t4_len", 32'(prog_len), 32'd64);
      chk("t4_noovf", 32'(overflow), 32'd0);
      send(8'h5A);
      chk("t4_ovf", 32'(overflow), 32'd1);
      chk("t4_len2", 32'(prog_len), 32'd64);
      instr_ready = 1'b1;
      pulse_start();
      for (int i = 0; i < 64; i++) begin
         chk("t4_v", 32'(instr_valid), 32'd1);
         chk("t4_w", instruccion, wgen(i));
         chk("t4_pc", 32'(pc), 32'(i));
         tick();
      end
      chk("t4_done", 32'(done), 32'd1);
      chk("t4_vend", 32'(instr_valid), 32'd0);
      chk("t4_ovf_sticky", 32'(overflow), 32'd1);

      // reset in the middle of RUN
      do_reset();
      chk("t5_ovf_clr", 32'(overflow), 32'd0);
      send_word(32'h00430820);
      send_word(32'h00A43022);
      instr_ready = 1'b0;
      pulse_start();
      instr_ready = 1'b1;
      tick();
      chk("t5_pc1", 32'(pc), 32'd1);
      chk("t5_v1", 32'(instr_valid), 32'd1);
      rst = 1'b1;
      #1;
      chk("t5_async_v", 32'(instr_valid), 32'd0);
      chk("t5_pc", 32'(pc), 32'd0);
      chk("t5_len", 32'(prog_len), 32'd0);
      chk("t5_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      tick();
      pulse_start();
      chk("t5_done", 32'(done), 32'd1);
      chk("t5_noissue", 32'(instr_valid), 32'd0);

      // opcode 6'b111111 handling
      do_reset();
      send_word(32'h00430820);
      send_word(32'hFC000000);
      send_word(32'h00A43022);
      pulse_start();
      chk("t6_w0", instruccion, 32'h00430820);
      chk("t6_v0", 32'(instr_valid), 32'd1);
      tick();
`ifdef HALT_OPCODE_EN
      chk("t6_halt_v", 32'(instr_valid), 32'd0);
      chk("t6_halt_done", 32'(done), 32'd1);
      chk("t6_halt_pc", 32'(pc), 32'd1);
`else
      chk("t6_w1", instruccion, 32'hFC000000);
      chk("t6_v1", 32'(instr_valid), 32'd1);
      tick();
      chk("t6_w2", instruccion, 32'h00A43022);
      tick();
      chk("t6_done", 32'(done), 32'd1);
      chk("t6_pc", 32'(pc), 32'd2);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
